// File: rtl/char_pkg.sv
// char_pkg: shared state encoding, glyph defaults and field widths for the character blitter.
package char_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, PLOT, DONE} state_t;
    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 10;
    localparam int CODE_W = 6;
    localparam int COLOUR_W = 6;
endpackage

// File: rtl/char_rr_arb.sv
// char_rr_arb: 2-way round-robin arbiter; pointer remembers the last winner.
module char_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    logic last;
    always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
    // last resets to req1 so req0 wins the first contested grant
    always_ff @(posedge clk or posedge reset)
        if (reset) last <= 1'b1;
        else if (en && |req) last <= gnt[1];
endmodule

// File: rtl/char_blit_ctrl.sv
// char_blit_ctrl: arbitrates two character requesters and scans a glyph cell,
// emitting one framebuffer write per lit pixel.
module char_blit_ctrl
    import char_pkg::*;
#(
    parameter int GLYPH_W = GLYPH_W_DEF,
    parameter int GLYPH_H = GLYPH_H_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [CODE_W-1:0]   req0_code,
    input  logic [7:0]          req0_x,
    input  logic [7:0]          req0_y,
    input  logic [COLOUR_W-1:0] req0_colour,
    input  logic [CODE_W-1:0]   req1_code,
    input  logic [7:0]          req1_x,
    input  logic [7:0]          req1_y,
    input  logic [COLOUR_W-1:0] req1_colour,
    output logic [CODE_W-1:0]   glyph_code,
    output logic [7:0]          glyph_dx,
    output logic [7:0]          glyph_dy,
    input  logic                glyph_hit,
    output logic                plot_valid,
    input  logic                plot_ready,
    output logic [7:0]          plot_x,
    output logic [7:0]          plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                busy,
    output logic                done
);
    state_t state;
    logic [7:0] dx, dy, x, y;
    logic [CODE_W-1:0] code;
    logic [COLOUR_W-1:0] colour;
    logic [1:0] gnt;
    logic idle, row_end, last_cell, step;
    assign idle = (state == IDLE) && !reset;
    char_rr_arb u_arb (
        .clk  (clk),
        .reset(reset),
        .req  ({req1_valid, req0_valid}),
        .en   (idle),
        .gnt  (gnt)
    );
    always_comb begin
        row_end   = dx == 8'(GLYPH_W - 1);
        last_cell = row_end && dy == 8'(GLYPH_H - 1);
        step      = (state == SCAN && !glyph_hit) || (state == PLOT && plot_ready);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            dx     <= '0;
            dy     <= '0;
            x      <= '0;
            y      <= '0;
            code   <= '0;
            colour <= '0;
        end else if (state == IDLE) begin
            if (|gnt) begin
                code   <= gnt[0] ? req0_code : req1_code;
                x      <= gnt[0] ? req0_x : req1_x;
                y      <= gnt[0] ? req0_y : req1_y;
                colour <= gnt[0] ? req0_colour : req1_colour;
                dx     <= '0;
                dy     <= '0;
                state  <= SCAN;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end else if (step) begin
            state <= last_cell ? DONE : SCAN;
            dx    <= row_end ? '0 : dx + 8'd1;
            dy    <= row_end ? dy + 8'd1 : dy;
        end else if (state == SCAN) begin
            state <= PLOT;
        end
    end
    assign req0_ready  = idle && gnt[0];
    assign req1_ready  = idle && gnt[1];
    assign glyph_code  = code;
    assign glyph_dx    = dx;
    assign glyph_dy    = dy;
    assign plot_valid  = state == PLOT;
    assign plot_x      = x + dx;
    assign plot_y      = y + dy;
    assign plot_colour = colour;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
endmodule

// File: tb/tb_char_blit_ctrl.sv
// tb_char_blit_ctrl: directed stimulus with a per-cycle reference model of grants, plots and completion.
module tb_char_blit_ctrl;
    localparam int W = 8;
    localparam int H = 10;

    logic clk = 0;
    logic reset = 1;
    logic req0_valid = 0, req1_valid = 0;
    logic req0_ready, req1_ready;
    logic [5:0] req0_code = 0, req1_code = 0, req0_colour = 0, req1_colour = 0;
    logic [7:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
    logic [5:0] glyph_code;
    logic [7:0] glyph_dx, glyph_dy;
    logic glyph_hit;
    logic plot_valid, plot_ready = 1;
    logic [7:0] plot_x, plot_y;
    logic [5:0] plot_colour;
    logic busy, done;

    always #5 clk = ~clk;

    char_blit_ctrl #(.GLYPH_W(W), .GLYPH_H(H)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_code(req0_code), .req0_x(req0_x), .req0_y(req0_y), .req0_colour(req0_colour),
        .req1_code(req1_code), .req1_x(req1_x), .req1_y(req1_y), .req1_colour(req1_colour),
        .glyph_code(glyph_code), .glyph_dx(glyph_dx), .glyph_dy(glyph_dy), .glyph_hit(glyph_hit),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy), .done(done)
    );

    // Glyph ROM: 0 blank, 1 bar row0 cols2..7, 2 single dot (7,0), 3 diagonal, 4 L-shape
    function automatic logic lut(input logic [5:0] c, input logic [7:0] gx, input logic [7:0] gy);
        case (c)
            6'd1: return gy == 0 && gx >= 2 && gx <= 7;
            6'd2: return gy == 0 && gx == 7;
            6'd3: return gx == gy;
            6'd4: return gx == 0 || gy == 9;
            default: return 1'b0;
        endcase
    endfunction
    assign glyph_hit = lut(glyph_code, glyph_dx, glyph_dy);

    typedef struct packed {logic [7:0] x; logic [7:0] y; logic [5:0] c;} pix_t;
    pix_t exp_q[$];
    pix_t log_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, gcyc = 0, stalls = 0, hits = 0, lat = 0;
    bit active = 0, last = 1;
    logic [1:0] exp_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic build(input logic [5:0] c, input logic [7:0] ox, input logic [7:0] oy, input logic [5:0] col);
        exp_q.delete();
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
                if (lut(c, 8'(i), 8'(j))) exp_q.push_back({8'(ox + 8'(i)), 8'(oy + 8'(j)), col});
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            check("reset_outputs", {req1_ready, req0_ready, plot_valid, plot_x, plot_y, plot_colour,
                                    glyph_code, glyph_dx, glyph_dy, busy, done}, 64'd0);
            exp_q.delete();
            active = 0;
            last = 1;
        end else begin
            exp_rdy = 2'b00;
            if (!active && (req0_valid || req1_valid))
                exp_rdy = (req0_valid && req1_valid) ? (last ? 2'b01 : 2'b10) : {req1_valid, req0_valid};
            check("ready", {req1_ready, req0_ready}, exp_rdy);
            check("busy", busy, active);
            check("done", done, active && (cyc == gcyc + 1 + W * H + hits + stalls));
            if (plot_valid) begin
                if (exp_q.size() == 0) check("plot_extra", 1, 0);
                else begin
                    check("plot", {plot_x, plot_y, plot_colour}, exp_q[0]);
                    if (plot_ready) begin
                        log_q.push_back({plot_x, plot_y, plot_colour});
                        void'(exp_q.pop_front());
                    end
                end
                if (!plot_ready) stalls++;
            end
            if (active && done) begin
                check("drained", exp_q.size(), 0);
                lat = cyc - gcyc;
                active = 0;
            end else if (exp_rdy != 2'b00) begin
                last = exp_rdy[1];
                if (exp_rdy[1]) build(req1_code, req1_x, req1_y, req1_colour);
                else build(req0_code, req0_x, req0_y, req0_colour);
                hits = exp_q.size();
                gcyc = cyc;
                stalls = 0;
                log_q.delete();
                active = 1;
            end
        end
    end

    task automatic wait_ready(input bit r);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (r ? req1_ready : req0_ready) return;
        end
        check("ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic wait_plot();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (plot_valid) return;
        end
        check("plot_timeout", 0, 1);
    endtask

    task automatic send(input bit r, input logic [5:0] c, input logic [7:0] ox, input logic [7:0] oy, input logic [5:0] col);
        if (r) begin
            req1_code = c; req1_x = ox; req1_y = oy; req1_colour = col; req1_valid = 1;
        end else begin
            req0_code = c; req0_x = ox; req0_y = oy; req0_colour = col; req0_valid = 1;
        end
        wait_ready(r);
        @(posedge clk);
        #1;
        if (r) req1_valid = 0;
        else req0_valid = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        check("reset_busy", busy, 0);
        #1 reset = 0;

        send(0, 6'd1, 8'd10, 8'd20, 6'd5);
        wait_done();
        check("bar_count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("bar_first", {log_q[0].x, log_q[0].y}, {8'd12, 8'd20});
            check("bar_last", {log_q[5].x, log_q[5].y}, {8'd17, 8'd20});
        end

        send(0, 6'd2, 8'd250, 8'd0, 6'd7);
        wait_done();
        check("wrap_count", log_q.size(), 1);
        if (log_q.size() == 1) check("wrap_x", log_q[0].x, 8'd1);

        send(1, 6'd0, 8'd3, 8'd4, 6'd1);
        wait_done();
        check("blank_latency", lat, 81);
        check("blank_plots", log_q.size(), 0);

        plot_ready = 0;
        send(0, 6'd3, 8'd100, 8'd50, 6'd9);
        wait_plot();
        repeat (5) begin
            @(negedge clk);
            check("stall_held", {plot_valid, plot_x, plot_y, plot_colour, glyph_dx, glyph_dy},
                  {1'b1, 8'd100, 8'd50, 6'd9, 8'd0, 8'd0});
        end
        @(posedge clk);
        #1 plot_ready = 1;
        wait_done();
        check("diag_count", log_q.size(), 8);
        if (log_q.size() == 8) check("diag_last", {log_q[7].x, log_q[7].y}, {8'd107, 8'd57});

        pulse_reset();
        req0_code = 6'd2; req0_x = 8'd0; req0_y = 8'd0; req0_colour = 6'd3;
        req1_code = 6'd1; req1_x = 8'd5; req1_y = 8'd5; req1_colour = 6'd4;
        req0_valid = 1;
        req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = req1_ready;
                    break;
                end
            end
            check("rr_order", got, k % 2);
        end
        @(posedge clk);
        #1 req0_valid = 0;
        req1_valid = 0;
        wait_done();

        plot_ready = 0;
        req0_code = 6'd4; req0_x = 8'd30; req0_y = 8'd40; req0_colour = 6'd2;
        req0_valid = 1;
        wait_ready(0);
        wait_plot();
        @(posedge clk);
        #1 reset = 1;
        #1 check("reset_drop", {plot_valid, busy}, 2'b00);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        wait_ready(0);
        @(posedge clk);
        #1 req0_valid = 0;
        plot_ready = 1;
        wait_done();
        check("regrant_count", log_q.size(), 17);
        if (log_q.size() == 17) check("regrant_first", {log_q[0].x, log_q[0].y}, {8'd30, 8'd40});

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
